// File: rtl/tmr_err_monitor.sv
// Collects TMR voter-mismatch error lines into a sticky source mask and a saturating
// error-cycle counter, and raises an acked level interrupt at a threshold. Define TMR_ERR_MON_SYNC_EN to synchronize err_i.
module tmr_err_monitor #(
  parameter int N_SRC  = 4,
  parameter int CNT_W  = 8,
  parameter int THRESH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_SRC-1:0] err_i,
  input  logic             clr_i,
  input  logic             ack_i,
  output logic             irq_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [N_SRC-1:0] err_src_o,
  output logic             sat_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PEND   = 2'd1;
  localparam logic [1:0] ST_MASKED = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  if (THRESH < 1 || THRESH > (1 << CNT_W) - 1) begin : g_thresh_check
    $error("tmr_err_monitor: THRESH must be in 1..2**CNT_W-1");
  end
  if (N_SRC < 1 || N_SRC > 32 || CNT_W < 2 || CNT_W > 16) begin : g_size_check
    $error("tmr_err_monitor: N_SRC or CNT_W out of range");
  end

  logic [N_SRC-1:0] err_s;

`ifdef TMR_ERR_MON_SYNC_EN
  // Two-flop synchronizer per line for error sources from foreign clock domains.
  logic [N_SRC-1:0] sync1_q, sync1_d;
  logic [N_SRC-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = err_i;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign err_s = sync2_q;
`else
  assign err_s = err_i;
`endif

  logic             ev;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_SRC-1:0] src_q, src_d;
  logic             irq_q, irq_d;
  logic             sat_q, sat_d;

  assign ev = |err_s;

  always_comb begin
    cnt_d = cnt_q;
    src_d = src_q | err_s;
    if (clr_i) begin
      cnt_d = ev ? CNT_W'(1) : '0;
      src_d = err_s;
    end else if (ev && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Clear restarts from IDLE but still honours a threshold hit by the clear cycle itself.
  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = (cnt_d >= THRESH_C) ? ST_PEND : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (cnt_d >= THRESH_C) state_d = ST_PEND;
        ST_PEND:   if (ack_i) state_d = ST_MASKED;
        ST_MASKED: state_d = ST_MASKED;
        default:   state_d = ST_IDLE;
      endcase
    end
    irq_d = (state_d == ST_PEND);
    sat_d = (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      irq_q   <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      irq_q   <= irq_d;
      sat_q   <= sat_d;
    end
  end

  assign irq_o     = irq_q;
  assign err_cnt_o = cnt_q;
  assign err_src_o = src_q;
  assign sat_o     = sat_q;

endmodule

// File: tb/tb_tmr_err_monitor.sv
// Directed self-checking bench for tmr_err_monitor: a default instance (4 sources,
// 8-bit counter, threshold 4) and a small one (1 source, 2-bit counter, threshold 3).
module tb_tmr_err_monitor;

`ifdef TMR_ERR_MON_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] err_i = '0;
  logic       clr_i = 1'b0;
  logic       ack_i = 1'b0;
  logic       irq_o;
  logic [7:0] err_cnt_o;
  logic [3:0] err_src_o;
  logic       sat_o;

  logic       s_err_i = 1'b0;
  logic       s_irq_o;
  logic [1:0] s_cnt_o;
  logic       s_src_o;
  logic       s_sat_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  tmr_err_monitor #(.N_SRC(4), .CNT_W(8), .THRESH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .err_i(err_i), .clr_i(clr_i), .ack_i(ack_i),
    .irq_o(irq_o), .err_cnt_o(err_cnt_o), .err_src_o(err_src_o), .sat_o(sat_o)
  );

  tmr_err_monitor #(.N_SRC(1), .CNT_W(2), .THRESH(3)) dut_s (
    .clk_i(clk), .rst_ni(rst_n), .err_i(s_err_i), .clr_i(1'b0), .ack_i(1'b0),
    .irq_o(s_irq_o), .err_cnt_o(s_cnt_o), .err_src_o(s_src_o), .sat_o(s_sat_o)
  );

  // One clock with the given inputs; inputs return to idle 1 time unit after the edge.
  task automatic step(input logic [3:0] e, input logic c, input logic a);
    err_i = e; clr_i = c; ack_i = a;
    @(posedge clk); #1;
    err_i = '0; clr_i = 1'b0; ack_i = 1'b0;
  endtask

  // Single error pulse, then wait out the synchronizer latency so outputs reflect it.
  task automatic pulse(input logic [3:0] e);
    step(e, 1'b0, 1'b0);
    repeat (LAT) step(4'b0000, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (20) step(4'b0000, 1'b0, 1'b0);
    chk_cnt++; if (irq_o !== 1'b0) $display("FAIL reset_irq: got %0b expected 0", irq_o); else pass_cnt++;
    chk_cnt++; if (err_cnt_o !== 8'd0) $display("FAIL reset_cnt: got %0d expected 0", err_cnt_o); else pass_cnt++;
    chk_cnt++; if (err_src_o !== 4'b0000) $display("FAIL reset_src: got %b expected 0000", err_src_o); else pass_cnt++;
    chk_cnt++; if (sat_o !== 1'b0) $display("FAIL reset_sat: got %0b expected 0", sat_o); else pass_cnt++;
    chk_cnt++; if (s_cnt_o !== 2'd0) $display("FAIL reset_s_cnt: got %0d expected 0", s_cnt_o); else pass_cnt++;
    $display("test_reset done: irq=%0b cnt=%0d src=%b sat=%0b", irq_o, err_cnt_o, err_src_o, sat_o);
  endtask

  task automatic test_threshold();
    logic [3:0] vec [4];
    vec[0] = 4'b0001; vec[1] = 4'b0100; vec[2] = 4'b0001; vec[3] = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      pulse(vec[i]);
      $display("threshold ev %0d: err=%b cnt=%0d irq=%0b", i, vec[i], err_cnt_o, irq_o);
      chk_cnt++;
      if (err_cnt_o !== 8'(i + 1)) $display("FAIL thr_cnt%0d: got %0d expected %0d", i, err_cnt_o, i + 1);
      else pass_cnt++;
      chk_cnt++;
      if (irq_o !== (i == 3)) $display("FAIL thr_irq%0d: got %0b expected %0b", i, irq_o, i == 3);
      else pass_cnt++;
    end
    chk_cnt++; if (err_src_o !== 4'b1101) $display("FAIL thr_src: got %b expected 1101", err_src_o); else pass_cnt++;
  endtask

  task automatic test_handshake();
    logic [3:0] vec [4];
    step(4'b0000, 1'b0, 1'b1);
    $display("handshake ack: irq=%0b", irq_o);
    chk_cnt++; if (irq_o !== 1'b0) $display("FAIL ack_irq: got %0b expected 0", irq_o); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      pulse(4'b0010);
      chk_cnt++; if (irq_o !== 1'b0) $display("FAIL masked_irq%0d: got %0b expected 0", i, irq_o); else pass_cnt++;
    end
    $display("handshake masked: cnt=%0d irq=%0b", err_cnt_o, irq_o);
    chk_cnt++; if (err_cnt_o !== 8'd7) $display("FAIL masked_cnt: got %0d expected 7", err_cnt_o); else pass_cnt++;
    step(4'b0000, 1'b1, 1'b0);
    $display("handshake clear: cnt=%0d src=%b irq=%0b", err_cnt_o, err_src_o, irq_o);
    chk_cnt++; if (err_cnt_o !== 8'd0) $display("FAIL clr_cnt: got %0d expected 0", err_cnt_o); else pass_cnt++;
    chk_cnt++; if (err_src_o !== 4'b0000) $display("FAIL clr_src: got %b expected 0000", err_src_o); else pass_cnt++;
    vec[0] = 4'b0001; vec[1] = 4'b0010; vec[2] = 4'b0100; vec[3] = 4'b1000;
    for (int i = 0; i < 4; i++) pulse(vec[i]);
    $display("handshake rearm: cnt=%0d src=%b irq=%0b", err_cnt_o, err_src_o, irq_o);
    chk_cnt++; if (irq_o !== 1'b1) $display("FAIL rearm_irq: got %0b expected 1", irq_o); else pass_cnt++;
    chk_cnt++; if (err_src_o !== 4'b1111) $display("FAIL rearm_src: got %b expected 1111", err_src_o); else pass_cnt++;
  endtask

  task automatic test_clear_collision();
    // Clear, ack and an error all land at the same sampling edge while in PEND.
    if (LAT == 0) begin
      step(4'b0010, 1'b1, 1'b1);
    end else begin
      step(4'b0010, 1'b0, 1'b0);
      repeat (LAT - 1) step(4'b0000, 1'b0, 1'b0);
      step(4'b0000, 1'b1, 1'b1);
    end
    $display("collision: cnt=%0d src=%b irq=%0b", err_cnt_o, err_src_o, irq_o);
    chk_cnt++; if (err_cnt_o !== 8'd1) $display("FAIL coll_cnt: got %0d expected 1", err_cnt_o); else pass_cnt++;
    chk_cnt++; if (err_src_o !== 4'b0010) $display("FAIL coll_src: got %b expected 0010", err_src_o); else pass_cnt++;
    chk_cnt++; if (irq_o !== 1'b0) $display("FAIL coll_irq: got %0b expected 0", irq_o); else pass_cnt++;
    // Back in IDLE (not MASKED): three more events reach the threshold and fire again.
    for (int i = 0; i < 3; i++) pulse(4'b0100);
    $display("collision rearm: cnt=%0d irq=%0b", err_cnt_o, irq_o);
    chk_cnt++; if (err_cnt_o !== 8'd4) $display("FAIL coll_rearm_cnt: got %0d expected 4", err_cnt_o); else pass_cnt++;
    chk_cnt++; if (irq_o !== 1'b1) $display("FAIL coll_rearm_irq: got %0b expected 1", irq_o); else pass_cnt++;
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt;
    s_err_i = 1'b1;
    repeat (LAT) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      exp_cnt = (i < 2) ? 2'(i + 1) : 2'd3;
      $display("saturate edge %0d: cnt=%0d sat=%0b irq=%0b", i + 1, s_cnt_o, s_sat_o, s_irq_o);
      chk_cnt++;
      if (s_cnt_o !== exp_cnt) $display("FAIL sat_cnt%0d: got %0d expected %0d", i + 1, s_cnt_o, exp_cnt);
      else pass_cnt++;
      chk_cnt++;
      if (s_sat_o !== (i >= 2)) $display("FAIL sat_flag%0d: got %0b expected %0b", i + 1, s_sat_o, i >= 2);
      else pass_cnt++;
      chk_cnt++;
      if (s_irq_o !== (i >= 2)) $display("FAIL sat_irq%0d: got %0b expected %0b", i + 1, s_irq_o, i >= 2);
      else pass_cnt++;
    end
    s_err_i = 1'b0;
  endtask

  task automatic test_async_reset();
    chk_cnt++; if (irq_o !== 1'b1) $display("FAIL pre_rst_irq: got %0b expected 1", irq_o); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: irq=%0b cnt=%0d src=%b sat=%0b s_sat=%0b", irq_o, err_cnt_o, err_src_o, sat_o, s_sat_o);
    chk_cnt++; if (irq_o !== 1'b0) $display("FAIL arst_irq: got %0b expected 0", irq_o); else pass_cnt++;
    chk_cnt++; if (err_cnt_o !== 8'd0) $display("FAIL arst_cnt: got %0d expected 0", err_cnt_o); else pass_cnt++;
    chk_cnt++; if (err_src_o !== 4'b0000) $display("FAIL arst_src: got %b expected 0000", err_src_o); else pass_cnt++;
    chk_cnt++; if (s_sat_o !== 1'b0) $display("FAIL arst_s_sat: got %0b expected 0", s_sat_o); else pass_cnt++;
    chk_cnt++; if (s_cnt_o !== 2'd0) $display("FAIL arst_s_cnt: got %0d expected 0", s_cnt_o); else pass_cnt++;
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (3) step(4'b0000, 1'b0, 1'b0);
    chk_cnt++; if (irq_o !== 1'b0) $display("FAIL post_rst_irq: got %0b expected 0", irq_o); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_handshake();
    test_clear_collision();
    test_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/tmr_err_monitor.md
# tmr_err_monitor

Downstream consumer of the `tmrx_error_sink` outputs from TMR-protected modules. It collects up to `N_SRC` voter-mismatch error lines and keeps a sticky per-source record of which lines have fired. It also counts error cycles with a saturating counter and raises a level interrupt, with an acknowledge handshake, once a programmable threshold is reached. It sits beside the top-level design and feeds the SoC interrupt/status logic.

## Interface
- `N_SRC`, 4: number of error source lines, 1..32
- `CNT_W`, 8: error-cycle counter width, 2..16
- `THRESH`, 4: count value that raises the interrupt, 1..2^CNT_W-1; 0 is illegal and is caught by an elaboration-time check

Ports:
- `clk_i`  in  1  clock, rising edge
- `rst_ni`  in  1  asynchronous active-low reset
- `err_i`  in  N_SRC  error lines from TMR error sinks, active high, level or pulse
- `clr_i`  in  1  single-cycle clear of counter, sticky mask and interrupt state
- `ack_i`  in  1  interrupt acknowledge
- `irq_o`  out  1  interrupt, level, registered
- `err_cnt_o`  out  CNT_W  number of cycles in which any `err_i` bit was high, saturating
- `err_src_o`  out  N_SRC  sticky OR of each `err_i` bit since the last clear
- `sat_o`  out  1  high while `err_cnt_o` equals all-ones

## Operation
- Per-cycle event: `ev = |err_s`, where `err_s` is `err_i`, or its synchronized copy (see Configuration).
- Counter:
  - On each edge with `ev`, `err_cnt_o` += 1.
  - It holds at 2^CNT_W-1; there is no wrap.
- Sticky mask: `err_src_o` <= `err_src_o | err_s` on every edge.
- FSM states:
  - `IDLE`: `irq_o`=0. Goes to `PEND` on the edge where the next counter value is >= `THRESH`.
  - `PEND`: `irq_o`=1. Goes to `MASKED` on the edge where `ack_i`=1. Further errors keep counting but do not re-raise the interrupt.
  - `MASKED`: `irq_o`=0. Stays here until `clr_i`; the counter and mask stay live.
- `clr_i`, in any state:
  - Next state is `IDLE`.
  - `err_src_o` <= `err_s`, so errors in the clear cycle are kept.
  - `err_cnt_o` <= `ev ? 1 : 0`.
  - Clear overrides `ack_i` and the threshold transition in the same cycle. If `THRESH`=1 and `ev`=1 during the clear, the next state is `PEND`.
- `ack_i` outside `PEND` is ignored.
- Reset (asynchronous, any time, including mid-`PEND`):
  - State goes to `IDLE`.
  - `irq_o`=0, `err_cnt_o`=0, `err_src_o`=0, `sat_o`=0.
  - Synchronizer flops are cleared to 0.

## Timing
- All outputs are registered; no combinational path from input to output.
- Without sync: `err_i` high before edge k means `err_cnt_o`/`err_src_o` update at edge k.
- `irq_o` rises at the same edge k at which the count reaches `THRESH`.
- `ack_i` sampled at edge k means `irq_o` is low after edge k.
- `clr_i` takes effect at the sampling edge: one cycle latency.
- `sat_o` is asserted in the same cycle the counter reaches all-ones.

## Configuration
- `TMR_ERR_MON_SYNC_EN` defined:
  - Each `err_i` bit passes through a 2-flop synchronizer (reset to 0) before use.
  - Latency from `err_i` to all outputs is +2 edges.
  - Use this for error lines from other clock domains.
- Undefined: `err_s = err_i` directly. Inputs must be synchronous to `clk_i`.

## Test plan
- Reset release with `err_i`=0 for 20 cycles -> all outputs 0, FSM in `IDLE`.
- `N_SRC`=4, `THRESH`=4:
  - Pulse `err_i`=4'b0001, 4'b0100, 4'b0001 on separate cycles, then 4'b1000 -> `err_cnt_o` goes 1,2,3,4; `err_src_o`=4'b1101.
  - `irq_o` rises on the 4th event edge.
- Interrupt handshake:
  - `irq_o`=1, assert `ack_i` one cycle -> `irq_o`=0 next cycle.
  - 3 more events -> count 7, `irq_o` stays 0.
  - `clr_i` -> count 0, mask 0.
  - 4 new events -> `irq_o`=1 again.
- `CNT_W`=2, `THRESH`=3: hold `err_i`=1 for 6 cycles -> count 1,2,3,3,3,3; `sat_o`=1 from the 3rd edge.
- Simultaneous `clr_i`, `ack_i` and `err_i`=4'b0010 while in `PEND` -> `err_cnt_o`=1, `err_src_o`=4'b0010, `irq_o`=0, FSM in `IDLE`.
- Assert `rst_ni`=0 mid-`PEND` between clock edges -> outputs go to 0 immediately, without waiting for a clock edge.
- With `TMR_ERR_MON_SYNC_EN` defined: the same event timing as the threshold test shows every output shifted by 2 cycles.
